// File: rtl/book_request_responder_if.sv
`timescale 1ns/1ps
// Request/response and query signals between the order-book driver (master)
// and the responder (slave). entry is packed as {price, order_id, quantity}.
interface book_request_responder_if #(
  parameter int unsigned NUM_STOCKS = 4,
  parameter int unsigned PRICE_W    = 16,
  parameter int unsigned ORDER_W    = 8,
  parameter int unsigned QTY_W      = 8
);
  localparam int unsigned SW = (NUM_STOCKS > 1) ? $clog2(NUM_STOCKS) : 1;
  localparam int unsigned EW = PRICE_W + ORDER_W + QTY_W;

  logic               start;
  logic [2:0]         request;
  logic [SW-1:0]      stock_to_add;
  logic [EW-1:0]      entry;
  logic [ORDER_W-1:0] order_id;
  logic [QTY_W-1:0]   quantity;
  logic               delete;
  logic               book_busy;
  logic               resp_valid;
  logic [2:0]         resp_code;
  logic [SW-1:0]      query_stock;
  logic [PRICE_W-1:0] best_price;
  logic               best_valid;

  modport master (
    output start, request, stock_to_add, entry, order_id, quantity, delete, query_stock,
    input  book_busy, resp_valid, resp_code, best_price, best_valid
  );

  modport slave (
    input  start, request, stock_to_add, entry, order_id, quantity, delete, query_stock,
    output book_busy, resp_valid, resp_code, best_price, best_valid
  );
endinterface

// File: rtl/book_request_responder.sv
`timescale 1ns/1ps
// Order-book responder: per-stock table of resting orders, a slot-by-slot scan,
// a one-cycle commit and a rescan that refreshes the registered best price.
module book_request_responder #(
  parameter int unsigned NUM_STOCKS = 4,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned PRICE_W    = 16,
  parameter int unsigned ORDER_W    = 8,
  parameter int unsigned QTY_W      = 8,
  parameter logic [2:0]  REQ_ADD    = 3'd0,
  parameter logic [2:0]  REQ_CANCEL = 3'd1
) (
  input logic                     clk_100mhz,
  input logic                     rst,
  book_request_responder_if.slave bus
);
  localparam int unsigned SW = (NUM_STOCKS > 1) ? $clog2(NUM_STOCKS) : 1;
  localparam int unsigned DW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned EW = PRICE_W + ORDER_W + QTY_W;
  localparam logic [DW-1:0] LastSlot = DW'(DEPTH - 1);

  localparam logic [2:0] RespOk       = 3'd0;
  localparam logic [2:0] RespDupId    = 3'd1;
  localparam logic [2:0] RespFull     = 3'd2;
  localparam logic [2:0] RespNotFound = 3'd3;
  localparam logic [2:0] RespBadReq   = 3'd4;

  typedef enum logic [1:0] {StIdle, StScan, StCommit, StRescan} state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic          cnt_last;

  logic [DEPTH-1:0]   slot_valid_q [NUM_STOCKS];
  logic [PRICE_W-1:0] slot_price_q [NUM_STOCKS][DEPTH];
  logic [ORDER_W-1:0] slot_id_q    [NUM_STOCKS][DEPTH];
  logic [QTY_W-1:0]   slot_qty_q   [NUM_STOCKS][DEPTH];

  logic [2:0]         req_q;
  logic [SW-1:0]      stock_q;
  logic [PRICE_W-1:0] price_in_q;
  logic [ORDER_W-1:0] target_id_q;
  logic [QTY_W-1:0]   qty_in_q;
  logic               delete_q;

  logic          found_q, free_found_q;
  logic [DW-1:0] match_idx_q, free_idx_q;
  logic [PRICE_W-1:0] max_q;
  logic          any_q;
  logic [2:0]    code_q;

  logic               resp_valid_q;
  logic [2:0]         resp_code_q;
  logic [PRICE_W-1:0] best_price_q [NUM_STOCKS];
  logic [NUM_STOCKS-1:0] best_valid_q;

  logic               accept_add;
  logic               is_add, stock_ok, req_ok;
  logic               cur_valid;
  logic [PRICE_W-1:0] cur_price;
  logic [QTY_W-1:0]   stored_qty;
  logic               cancel_removes;
  logic [2:0]         commit_code;
  logic               commit_ok;
  logic [PRICE_W-1:0] max_next;
  logic               any_next;

  assign cnt_last   = (cnt_q == LastSlot);
  assign accept_add = (bus.request == REQ_ADD);
  assign is_add     = (req_q == REQ_ADD);
  assign stock_ok   = (32'(stock_q) < NUM_STOCKS);
  assign req_ok     = stock_ok && (is_add || req_q == REQ_CANCEL);

  // The slot under the counter serves both the scan and the rescan.
  assign cur_valid      = slot_valid_q[stock_q][cnt_q];
  assign cur_price      = slot_price_q[stock_q][cnt_q];
  assign stored_qty     = slot_qty_q[stock_q][match_idx_q];
  assign cancel_removes = delete_q || (qty_in_q >= stored_qty);
  assign max_next       = (cur_valid && cur_price > max_q) ? cur_price : max_q;
  assign any_next       = any_q | cur_valid;

  always_comb begin
    commit_code = RespOk;
    if (!req_ok) begin
      commit_code = RespBadReq;
    end else if (is_add) begin
      if (found_q)            commit_code = RespDupId;
      else if (!free_found_q) commit_code = RespFull;
    end else if (!found_q) begin
      commit_code = RespNotFound;
    end
  end

  assign commit_ok = (state_q == StCommit) && (commit_code == RespOk);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StScan;
          cnt_d   = '0;
        end
      end
      StScan: begin
        if (cnt_last) begin
          state_d = StCommit;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StCommit: state_d = StRescan;
      StRescan: begin
        if (cnt_last) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      for (int unsigned s = 0; s < NUM_STOCKS; s++) begin
        slot_valid_q[s] <= '0;
        best_price_q[s] <= '0;
      end
      best_valid_q <= '0;
      resp_valid_q <= 1'b0;
      resp_code_q  <= RespOk;
      req_q        <= '0;
      stock_q      <= '0;
      price_in_q   <= '0;
      target_id_q  <= '0;
      qty_in_q     <= '0;
      delete_q     <= 1'b0;
      found_q      <= 1'b0;
      free_found_q <= 1'b0;
      match_idx_q  <= '0;
      free_idx_q   <= '0;
      max_q        <= '0;
      any_q        <= 1'b0;
      code_q       <= RespOk;
    end else begin
      resp_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            req_q        <= bus.request;
            stock_q      <= bus.stock_to_add;
            price_in_q   <= bus.entry[EW-1 -: PRICE_W];
            target_id_q  <= accept_add ? bus.entry[QTY_W +: ORDER_W] : bus.order_id;
            qty_in_q     <= accept_add ? bus.entry[QTY_W-1:0] : bus.quantity;
            delete_q     <= bus.delete;
            found_q      <= 1'b0;
            free_found_q <= 1'b0;
            max_q        <= '0;
            any_q        <= 1'b0;
          end
        end
        StScan: begin
          if (cur_valid) begin
            if (!found_q && slot_id_q[stock_q][cnt_q] == target_id_q) begin
              found_q     <= 1'b1;
              match_idx_q <= cnt_q;
            end
          end else if (!free_found_q) begin
            free_found_q <= 1'b1;
            free_idx_q   <= cnt_q;
          end
        end
        StCommit: begin
          code_q <= commit_code;
          if (commit_ok) begin
            if (is_add)              slot_valid_q[stock_q][free_idx_q]  <= 1'b1;
            else if (cancel_removes) slot_valid_q[stock_q][match_idx_q] <= 1'b0;
          end
        end
        StRescan: begin
          max_q <= max_next;
          any_q <= any_next;
          if (cnt_last) begin
            if (stock_ok) begin
              best_price_q[stock_q] <= any_next ? max_next : '0;
              best_valid_q[stock_q] <= any_next;
            end
            resp_valid_q <= 1'b1;
            resp_code_q  <= code_q;
          end
        end
        default: ;
      endcase
    end
  end

  // Slot payload needs no reset: it is only observed through its valid bit.
  always_ff @(posedge clk_100mhz) begin
    if (!rst && commit_ok) begin
      if (is_add) begin
        slot_price_q[stock_q][free_idx_q] <= price_in_q;
        slot_id_q[stock_q][free_idx_q]    <= target_id_q;
        slot_qty_q[stock_q][free_idx_q]   <= qty_in_q;
      end else if (!cancel_removes) begin
        slot_qty_q[stock_q][match_idx_q] <= stored_qty - qty_in_q;
      end
    end
  end

  assign bus.book_busy  = (state_q != StIdle);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_code  = resp_code_q;
  assign bus.best_price = best_price_q[bus.query_stock];
  assign bus.best_valid = best_valid_q[bus.query_stock];

endmodule

// File: tb/tb_book_request_responder.sv
`timescale 1ns/1ps
// Randomised bench for book_request_responder: queue-based order-book model,
// expected responses pushed at issue and checked by an independent monitor.
module tb_book_request_responder;
  localparam int unsigned NS = 4;
  localparam int unsigned D  = 8;
  localparam logic [2:0] ADD = 3'd0;
  localparam logic [2:0] CAN = 3'd1;

  logic clk_100mhz = 1'b0;
  logic rst;
  always #5 clk_100mhz = ~clk_100mhz;

  book_request_responder_if #(.NUM_STOCKS(NS), .PRICE_W(16), .ORDER_W(8), .QTY_W(8)) bus ();

  book_request_responder #(
    .NUM_STOCKS(NS), .DEPTH(D), .PRICE_W(16), .ORDER_W(8), .QTY_W(8),
    .REQ_ADD(ADD), .REQ_CANCEL(CAN)
  ) dut (
    .clk_100mhz(clk_100mhz),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {logic [15:0] price; logic [7:0] id; logic [7:0] qty;} order_t;
  typedef struct packed {logic [2:0] code; logic [15:0] best; logic bvalid;} exp_t;

  order_t book[NS][$];
  exp_t   exp_q[$];
  int     n_checks = 0;
  int     n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  // Orders kept as an unordered list per stock; slot placement is irrelevant here.
  function automatic logic [2:0] model_apply(input logic [2:0] rq, input int s,
      input logic [15:0] pr, input logic [7:0] id, input logic [7:0] q, input logic del);
    int idx = -1;
    order_t o;
    order_t keep[$];
    if ((rq != ADD && rq != CAN) || s >= int'(NS)) return 3'd4;
    for (int i = 0; i < book[s].size(); i++) if (book[s][i].id == id) idx = i;
    if (rq == ADD) begin
      if (idx >= 0) return 3'd1;
      if (book[s].size() >= int'(D)) return 3'd2;
      o.price = pr; o.id = id; o.qty = q;
      book[s].push_back(o);
      return 3'd0;
    end
    if (idx < 0) return 3'd3;
    if (del || q >= book[s][idx].qty) begin
      for (int i = 0; i < book[s].size(); i++) if (i != idx) keep.push_back(book[s][i]);
      book[s] = keep;
    end else begin
      book[s][idx].qty = book[s][idx].qty - q;
    end
    return 3'd0;
  endfunction

  task automatic model_best(input int s, output logic [15:0] b, output logic v);
    b = 16'h0;
    v = (book[s].size() != 0);
    for (int i = 0; i < book[s].size(); i++) if (book[s][i].price > b) b = book[s][i].price;
  endtask

  task automatic model_clear();
    for (int s = 0; s < int'(NS); s++) while (book[s].size() != 0) void'(book[s].pop_back());
  endtask

  // Monitor: every response must match the oldest outstanding expectation.
  always @(negedge clk_100mhz) begin
    if (bus.resp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_resp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("resp_code", bus.resp_code, e.code);
        check("best_price", bus.best_price, e.best);
        check("best_valid", bus.best_valid, e.bvalid);
      end
    end
  end

  task automatic issue(input logic [2:0] rq, input int s, input logic [15:0] pr,
      input logic [7:0] id, input logic [7:0] q, input logic del, input int hold);
    exp_t e;
    int   lat = -1;
    logic busy_ok = 1'b1;
    logic busy_at_resp = 1'b1;
    e.code = model_apply(rq, s, pr, id, q, del);
    model_best(s, e.best, e.bvalid);
    exp_q.push_back(e);
    @(negedge clk_100mhz);
    bus.start        = 1'b1;
    bus.request      = rq;
    bus.stock_to_add = 2'(s);
    bus.query_stock  = 2'(s);
    bus.delete       = del;
    if (rq == CAN) begin
      bus.entry    = $urandom;
      bus.order_id = id;
      bus.quantity = q;
    end else begin
      bus.entry    = {pr, id, q};
      bus.order_id = 8'($urandom);
      bus.quantity = 8'($urandom);
    end
    @(posedge clk_100mhz);
    for (int k = 1; k <= int'(2 * D + 6) && lat < 0; k++) begin
      @(negedge clk_100mhz);
      if (bus.resp_valid) begin
        lat = k;
        busy_at_resp = bus.book_busy;
      end else if (!bus.book_busy) begin
        busy_ok = 1'b0;
      end
      if (k >= hold) bus.start = 1'b0;
    end
    bus.start = 1'b0;
    check("latency", lat, 2 * D + 2);
    check("busy_span", busy_ok, 1'b1);
    check("busy_at_resp", busy_at_resp, 1'b0);
  endtask

  task automatic check_all_idle(input string tag);
    for (int s = 0; s < int'(NS); s++) begin
      bus.query_stock = 2'(s);
      #1;
      check({tag, "_best_valid"}, bus.best_valid, 1'b0);
      check({tag, "_best_price"}, bus.best_price, 16'h0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.request = '0; bus.stock_to_add = '0; bus.entry = '0;
    bus.order_id = '0; bus.quantity = '0; bus.delete = 1'b0; bus.query_stock = '0;
    repeat (3) @(posedge clk_100mhz);
    @(negedge clk_100mhz);
    check("rst_busy", bus.book_busy, 1'b0);
    check("rst_resp_valid", bus.resp_valid, 1'b0);
    check("rst_resp_code", bus.resp_code, 3'd0);
    check_all_idle("rst");
    rst = 1'b0;

    // Single add, then delete and a repeated delete.
    issue(ADD, 2, 16'h1F00, 8'd1, 8'd1, 1'b0, 1);
    issue(CAN, 2, 16'h0, 8'd1, 8'd0, 1'b1, 1);
    issue(CAN, 2, 16'h0, 8'd1, 8'd0, 1'b1, 1);

    // Fill stock 0, overflow, miss, duplicate.
    for (int i = 1; i <= int'(D); i++) issue(ADD, 0, 16'($urandom), 8'(i), 8'd4, 1'b0, 1);
    issue(ADD, 0, 16'h4000, 8'd9, 8'd1, 1'b0, 1);
    issue(CAN, 0, 16'h0, 8'd9, 8'd1, 1'b1, 1);
    issue(ADD, 0, 16'h4000, 8'd3, 8'd1, 1'b0, 1);

    // Best tracks the max and falls back when the max order is removed by quantity.
    issue(ADD, 1, 16'h2000, 8'd1, 8'd1, 1'b0, 1);
    issue(ADD, 1, 16'h3000, 8'd2, 8'd1, 1'b0, 1);
    issue(CAN, 1, 16'h0, 8'd2, 8'd5, 1'b0, 1);

    // Partial cancels, zero-quantity cancel, held strobe, bad request code.
    issue(ADD, 3, 16'h0180, 8'd5, 8'd10, 1'b0, 2);
    issue(CAN, 3, 16'h0, 8'd5, 8'd0, 1'b0, 1);
    issue(CAN, 3, 16'h0, 8'd5, 8'd3, 1'b0, 1);
    issue(CAN, 3, 16'h0, 8'd5, 8'd7, 1'b0, 1);
    issue(3'd7, 3, 16'h7777, 8'd6, 8'd1, 1'b0, 1);

    // Reset in the middle of a scan aborts the add.
    @(negedge clk_100mhz);
    bus.start = 1'b1; bus.request = ADD; bus.stock_to_add = 2'd1;
    bus.entry = {16'h5555, 8'd7, 8'd1};
    @(posedge clk_100mhz);
    @(negedge clk_100mhz);
    bus.start = 1'b0;
    repeat (2) @(negedge clk_100mhz);
    rst = 1'b1;
    @(posedge clk_100mhz);
    @(negedge clk_100mhz);
    check("midrst_busy", bus.book_busy, 1'b0);
    check("midrst_resp_valid", bus.resp_valid, 1'b0);
    rst = 1'b0;
    check_all_idle("midrst");
    model_clear();
    issue(ADD, 1, 16'h0101, 8'd7, 8'd1, 1'b0, 1);

    for (int n = 0; n < 160; n++) begin
      int r;
      logic [2:0] rq;
      r  = $urandom_range(0, 9);
      rq = (r < 4) ? ADD : (r < 8) ? CAN : 3'($urandom_range(2, 7));
      issue(rq, $urandom_range(0, NS - 1), 16'($urandom), 8'($urandom_range(1, 12)),
            (rq == CAN) ? 8'($urandom_range(0, 6)) : 8'($urandom_range(1, 255)),
            1'($urandom_range(0, 1)), $urandom_range(1, 2));
    end

    repeat (5) @(negedge clk_100mhz);
    check("outstanding_resp", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
